// File: rtl/sdram_pkg.sv
// sdram_pkg
//   Shared definitions for the SDRAM power-up init monitor and anything else
//   that has to agree with it on command encodings, error codes or the
//   monitor's state encoding (for example, the controller's assertions).
//
//   Contents:
//     NOP/PRE/AREF/MSET  raw {cs_n,ras_n,cas_n,we_n} command encodings
//     cmd_kind_e         decoded command class
//     err_code_e         first-violation code reported by the monitor
//     state_e            init monitor FSM state encoding
//     decode_cmd()       maps a raw command nibble to its cmd_kind_e
package sdram_pkg;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MSET = 4'b0000;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_PRE   = 3'd1,
    CMD_AREF  = 3'd2,
    CMD_MSET  = 3'd3,
    CMD_OTHER = 3'd4
  } cmd_kind_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_EARLY    = 3'd1,
    ERR_ORDER    = 3'd2,
    ERR_TRP      = 3'd3,
    ERR_TRFC     = 3'd4,
    ERR_NO_A10   = 3'd5,
    ERR_BAD_MODE = 3'd6,
    ERR_TMRD     = 3'd7
  } err_code_e;

  typedef enum logic [2:0] {
    ST_WAIT_PWR  = 3'd0,
    ST_WAIT_AREF = 3'd1,
    ST_WAIT_MRD  = 3'd2,
    ST_DONE      = 3'd3,
    ST_ERR       = 3'd4
  } state_e;

  // A deselected device (cs_n high) sees nothing, so every code with cs_n=1
  // is treated the same as an explicit NOP.
  function automatic cmd_kind_e decode_cmd(input logic [3:0] cmd);
    cmd_kind_e kind;
    kind = CMD_OTHER;
    if (cmd[3]) begin
      kind = CMD_NOP;
    end else begin
      unique case (cmd)
        NOP:     kind = CMD_NOP;
        PRE:     kind = CMD_PRE;
        AREF:    kind = CMD_AREF;
        MSET:    kind = CMD_MSET;
        default: kind = CMD_OTHER;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/sdram_mode_check.sv
// sdram_mode_check
//   Purely combinational legality check of a 13-bit SDRAM mode register word
//   as driven on the address bus during MODE REGISTER SET.
//
//   Ports:
//     mode_word [12:0]  in   candidate mode register value
//     cas_ok            out  CAS latency field [6:4] is 2 or 3
//     bl_ok             out  burst length field [2:0] is 0,1,2,3 or 7
//     rsvd_ok           out  reserved bits A12:A10 are all zero
//     mode_ok           out  all of the above hold
module sdram_mode_check (
  input  logic [12:0] mode_word,
  output logic        cas_ok,
  output logic        bl_ok,
  output logic        rsvd_ok,
  output logic        mode_ok
);

  // Burst type (A3) and write-burst/op-mode bits (A9:A7) are not policed.
  logic unused_mode_bits;

  always_comb begin
    cas_ok  = (mode_word[6:4] == 3'd2) || (mode_word[6:4] == 3'd3);
    // Codes 4..6 are reserved; 7 is full page.
    bl_ok   = (mode_word[2:0] <= 3'd3) || (mode_word[2:0] == 3'd7);
    rsvd_ok = (mode_word[12:10] == 3'b000);
    mode_ok = cas_ok && bl_ok && rsvd_ok;
    unused_mode_bits = ^{mode_word[9:7], mode_word[3]};
  end

endmodule

// File: rtl/sdram_init_monitor.sv
// sdram_init_monitor
//   Device-side responder/checker for the SDRAM power-up init sequence:
//   NOP wait, PRECHARGE-ALL, AUTO-REFRESH x N, MODE REGISTER SET. It checks
//   command order and minimum gaps, latches the programmed mode word and
//   reports a sticky done flag or a sticky first-violation code.
//
//   Optional build macro: SDRAM_INIT_MON_CYC_EN adds the init_cycles output,
//   a saturating count of cycles from reset release until init_done rises
//   (frozen on completion or on entry to the error state).
//
//   Ports:
//     sclk              in   system clock, rising edge
//     s_rst             in   synchronous active-high reset
//     cmd_reg    [3:0]  in   {cs_n, ras_n, cas_n, we_n}
//     sdram_addr [12:0] in   address bus (A10 and the mode field are used)
//     init_done         out  sequence completed legally (sticky)
//     init_err          out  sequence violation seen (sticky)
//     err_code   [2:0]  out  first violation code, 0 = none
//     mode_reg   [12:0] out  address word latched on the MSET
//     cas_lat    [2:0]  out  mode_reg[6:4]
//     burst_len  [2:0]  out  mode_reg[2:0]
//     init_cycles[15:0] out  (SDRAM_INIT_MON_CYC_EN only) cycles to init_done
module sdram_init_monitor
  import sdram_pkg::*;
#(
  parameter int unsigned DELAY_200US = 20000,
  parameter int unsigned T_RP_CYC    = 2,
  parameter int unsigned T_RFC_CYC   = 7,
  parameter int unsigned T_MRD_CYC   = 2,
  parameter int unsigned AREF_NUM    = 2
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic [3:0]  cmd_reg,
  input  logic [12:0] sdram_addr,
  output logic        init_done,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic [12:0] mode_reg,
  output logic [2:0]  cas_lat,
  output logic [2:0]  burst_len
`ifdef SDRAM_INIT_MON_CYC_EN
  ,
  output logic [15:0] init_cycles
`endif
);

  state_e      state_q, state_d;
  err_code_e   err_code_q, err_code_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [12:0] mode_reg_q, mode_reg_d;
  logic [14:0] pwr_cnt_q, pwr_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  aref_cnt_q, aref_cnt_d;
  // Remembers whether the most recent command was AREF (else PRE), which
  // selects the gap the next command must honour.
  logic        last_aref_q, last_aref_d;

  cmd_kind_e   cmd_kind;
  err_code_e   violation;
  logic        is_cmd;
  logic        pwr_ok;
  logic        aref_ok;
  logic        gap_ok;
  logic        mrd_elapsed;
  logic [31:0] gap_req;
  logic [31:0] gap_plus1;
  logic        mode_ok;
  logic        mode_cas_ok;
  logic        mode_bl_ok;
  logic        mode_rsvd_ok;

  sdram_mode_check u_mode_check (
    .mode_word (sdram_addr),
    .cas_ok    (mode_cas_ok),
    .bl_ok     (mode_bl_ok),
    .rsvd_ok   (mode_rsvd_ok),
    .mode_ok   (mode_ok)
  );

  // Only the combined verdict drives the FSM; the per-field flags exist for
  // other users of the checker.
  logic unused_mode_flags;
  assign unused_mode_flags = mode_cas_ok ^ mode_bl_ok ^ mode_rsvd_ok;

  // Condition decode. gap_cnt holds (cycles since last command - 1), so the
  // distance from that command to the current cycle is gap_cnt + 1.
  always_comb begin
    cmd_kind  = decode_cmd(cmd_reg);
    is_cmd    = (cmd_kind != CMD_NOP);
    pwr_ok    = (32'(pwr_cnt_q) >= DELAY_200US);
    aref_ok   = (32'(aref_cnt_q) >= AREF_NUM);
    gap_req   = last_aref_q ? T_RFC_CYC : T_RP_CYC;
    gap_plus1 = 32'(gap_cnt_q) + 32'd1;
    gap_ok    = (gap_plus1 >= gap_req);
    // init_done must be visible T_MRD_CYC cycles after the MSET, so the
    // flag is registered on the edge one cycle earlier (distance + 1).
    mrd_elapsed = ((gap_plus1 + 32'd1) >= T_MRD_CYC);
  end

  // Free-running counters: power-up wait counter (only in WAIT_PWR) and the
  // gap counter, both saturating.
  always_comb begin
    pwr_cnt_d = pwr_cnt_q;
    if ((state_q == ST_WAIT_PWR) && (pwr_cnt_q != '1)) begin
      pwr_cnt_d = pwr_cnt_q + 15'd1;
    end
    gap_cnt_d = gap_cnt_q;
    if (is_cmd) begin
      gap_cnt_d = '0;
    end else if (gap_cnt_q != '1) begin
      gap_cnt_d = gap_cnt_q + 8'd1;
    end
  end

  // Sequence FSM. Each state decides a transition or a violation; a detected
  // violation overrides any transition so the state never advances on an
  // illegal command, and the first code is frozen by the ERR state.
  always_comb begin
    state_d     = state_q;
    err_code_d  = err_code_q;
    err_d       = err_q;
    done_d      = done_q;
    mode_reg_d  = mode_reg_q;
    aref_cnt_d  = aref_cnt_q;
    last_aref_d = last_aref_q;
    violation   = ERR_NONE;

    unique case (state_q)
      ST_WAIT_PWR: begin
        if (is_cmd) begin
          if (!pwr_ok) begin
            violation = ERR_EARLY;
          end else if (cmd_kind == CMD_PRE) begin
            if (sdram_addr[10]) begin
              state_d     = ST_WAIT_AREF;
              last_aref_d = 1'b0;
            end else begin
              violation = ERR_NO_A10;
            end
          end else begin
            violation = ERR_ORDER;
          end
        end
      end

      ST_WAIT_AREF: begin
        unique case (cmd_kind)
          CMD_AREF: begin
            if (!gap_ok) begin
              violation = last_aref_q ? ERR_TRFC : ERR_TRP;
            end else begin
              if (aref_cnt_q != '1) begin
                aref_cnt_d = aref_cnt_q + 8'd1;
              end
              last_aref_d = 1'b1;
            end
          end
          CMD_MSET: begin
            if (!aref_ok) begin
              violation = ERR_ORDER;
            end else if (!gap_ok) begin
              violation = last_aref_q ? ERR_TRFC : ERR_TRP;
            end else begin
              // The word is kept even when its fields are illegal so the
              // offending value can be inspected.
              mode_reg_d = sdram_addr;
              if (!mode_ok) begin
                violation = ERR_BAD_MODE;
              end else begin
                state_d = ST_WAIT_MRD;
              end
            end
          end
          CMD_PRE, CMD_OTHER: begin
            violation = ERR_ORDER;
          end
          default: begin
          end
        endcase
      end

      ST_WAIT_MRD: begin
        if (is_cmd) begin
          violation = ERR_TMRD;
        end else if (mrd_elapsed) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE, ST_ERR: begin
      end

      default: begin
      end
    endcase

    if (violation != ERR_NONE) begin
      state_d    = ST_ERR;
      err_d      = 1'b1;
      err_code_d = violation;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q     <= ST_WAIT_PWR;
      err_code_q  <= ERR_NONE;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mode_reg_q  <= '0;
      pwr_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      aref_cnt_q  <= '0;
      last_aref_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mode_reg_q  <= mode_reg_d;
      pwr_cnt_q   <= pwr_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      aref_cnt_q  <= aref_cnt_d;
      last_aref_q <= last_aref_d;
    end
  end

`ifdef SDRAM_INIT_MON_CYC_EN
  logic [15:0] cyc_q, cyc_d;

  // Counts every cycle spent still working through the sequence; the edge
  // that registers init_done is counted, after which DONE/ERR freeze it.
  always_comb begin
    cyc_d = cyc_q;
    if ((state_q != ST_DONE) && (state_q != ST_ERR) && (cyc_q != '1)) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign init_cycles = cyc_q;
`endif

  assign init_done = done_q;
  assign init_err  = err_q;
  assign err_code  = err_code_q;
  assign mode_reg  = mode_reg_q;
  assign cas_lat   = mode_reg_q[6:4];
  assign burst_len = mode_reg_q[2:0];

endmodule
